// File: rtl/matmul_tn_operand_feeder_if.sv
// matmul_tn_operand_feeder_if: operand stream (valid_out/ready_in/data_a/data_b/last_k) and result return (valid_in/result)
interface matmul_tn_operand_feeder_if #(parameter int DW = 32);
  logic valid_out, ready_in, last_k, valid_in;
  logic [DW-1:0] data_a, data_b, result;
  modport master(output valid_out, data_a, data_b, last_k, input ready_in, valid_in, result);
  modport slave(input valid_out, data_a, data_b, last_k, output ready_in, valid_in, result);
endinterface

// File: rtl/matmul_tn_operand_feeder.sv
// matmul_tn_operand_feeder: host loads A/B (wr_*), start streams A^T*B operand pairs on bus, results land in C (rd_addr/rd_data), status busy/done/overrun
module matmul_tn_operand_feeder #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int K = 4,
  parameter int DW = 32,
  localparam int AW = $clog2(K * (M > N ? M : N)),
  localparam int CW = $clog2(M * N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  input  logic [CW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  matmul_tn_operand_feeder_if.master bus
);
  localparam int MC = $clog2(M) + 1;
  localparam int NC = $clog2(N) + 1;
  localparam int KC = $clog2(K) + 1;
  localparam int RC = CW + 1;
  typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_t;
  state_t state, state_n;
  logic [MC-1:0] m;
  logic [NC-1:0] n;
  logic [KC-1:0] k;
  logic [RC-1:0] res_cnt;
  logic [DW-1:0] a_mem [2**AW];
  logic [DW-1:0] b_mem [2**AW];
  logic [DW-1:0] c_mem [2**CW];
  logic [AW-1:0] a_idx, b_idx;
  logic xfer, k_end, n_end, m_end, res_full, res_ok;
  assign a_idx = AW'(int'(k) * M + int'(m));
  assign b_idx = AW'(int'(k) * N + int'(n));
  assign k_end = k == KC'(K - 1);
  assign n_end = n == NC'(N - 1);
  assign m_end = m == MC'(M - 1);
  assign xfer = bus.valid_out && bus.ready_in;
  assign res_full = res_cnt == RC'(M * N);
  assign res_ok = bus.valid_in && state != IDLE && !res_full;
  assign busy = state != IDLE;
  assign done = state == WAIT && res_full;
  assign bus.valid_out = state == STREAM;
  assign bus.last_k = bus.valid_out && k_end;
  assign bus.data_a = bus.valid_out ? a_mem[a_idx] : '0;
  assign bus.data_b = bus.valid_out ? b_mem[b_idx] : '0;
  assign rd_data = c_mem[rd_addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = STREAM;
    else if (state == STREAM && xfer && k_end && n_end && m_end) state_n = WAIT;
    else if (state == WAIT && res_full) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m <= '0;
      n <= '0;
      k <= '0;
      res_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        m <= '0;
        n <= '0;
        k <= '0;
        res_cnt <= '0;
        overrun <= 1'b0;
      end else if (xfer) begin
        k <= k_end ? '0 : k + KC'(1);
        if (k_end) n <= n_end ? '0 : n + NC'(1);
        if (k_end && n_end) m <= m + MC'(1);
      end
      if (res_ok) res_cnt <= res_cnt + RC'(1);
      else if (bus.valid_in) overrun <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en && !wr_sel && {1'b0, wr_addr} < (AW+1)'(K * M)) a_mem[wr_addr] <= wr_data;
    if (state == IDLE && wr_en && wr_sel && {1'b0, wr_addr} < (AW+1)'(K * N)) b_mem[wr_addr] <= wr_data;
    if (res_ok) c_mem[CW'(res_cnt)] <= bus.result;
  end
endmodule

// File: tb/tb_matmul_tn_operand_feeder.sv
// tb_matmul_tn_operand_feeder: directed runs against a sequence/matrix model with a 3-cycle loopback datapath
module tb_matmul_tn_operand_feeder;
  localparam int M = 4, N = 4, K = 4, DW = 32;
  typedef struct {int due; logic [31:0] v;} res_t;
  logic clk = 0, rst_n = 0, wr_en = 0, wr_sel = 0, start = 0;
  logic [3:0] wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic busy, done, overrun;
  logic [31:0] rd_data;
  matmul_tn_operand_feeder_if #(.DW(DW)) bus();
  matmul_tn_operand_feeder #(.M(M), .N(N), .K(K), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .overrun(overrun),
    .rd_addr(rd_addr), .rd_data(rd_data), .bus(bus)
  );
  always #5 clk = ~clk;
  logic [31:0] am [16], bm [16];
  logic [31:0] exp_a [$], exp_b [$];
  bit exp_l [$];
  res_t rq [$];
  int tests = 0, fails = 0, cyc = 0, idx = 0, lastk_cnt = 0, res_seen = 0;
  int last_res_cyc = 0, done_cnt = 0, done_cyc = 0;
  logic [31:0] acc = 0, pa = 0, pb = 0;
  logic pl = 0, pstall = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] c_exp(int i);
    logic [31:0] s = 0;
    for (int kk = 0; kk < K; kk++) s += am[kk*M + i/N] * bm[kk*N + i%N];
    return s;
  endfunction
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      bus.valid_in = 1'b1;
      bus.result = rq[0].v;
      void'(rq.pop_front());
    end else begin
      bus.valid_in = 1'b0;
      bus.result = '0;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      idx = 0;
      acc = 0;
      pstall = 0;
    end else begin
      if (bus.valid_out && pstall) begin
        tests++;
        if (bus.data_a !== pa || bus.data_b !== pb || bus.last_k !== pl) begin
          fails++;
          $display("FAIL stall_hold: got a=%0h b=%0h l=%0b expected a=%0h b=%0h l=%0b", bus.data_a, bus.data_b, bus.last_k, pa, pb, pl);
        end
      end
      if (bus.valid_out && bus.ready_in) begin
        tests++;
        if (idx >= exp_a.size()) begin
          fails++;
          $display("FAIL extra_xfer: got transfer %0d expected at most %0d", idx + 1, exp_a.size());
        end else if (bus.data_a !== exp_a[idx] || bus.data_b !== exp_b[idx] || bus.last_k !== exp_l[idx]) begin
          fails++;
          $display("FAIL xfer%0d: got a=%0h b=%0h l=%0b expected a=%0h b=%0h l=%0b", idx, bus.data_a, bus.data_b, bus.last_k, exp_a[idx], exp_b[idx], exp_l[idx]);
        end
        if (bus.last_k) begin
          lastk_cnt++;
          rq.push_back('{cyc + 3, acc + bus.data_a * bus.data_b});
          acc = 0;
        end else acc += bus.data_a * bus.data_b;
        idx++;
      end
      pstall = bus.valid_out && !bus.ready_in;
      pa = bus.data_a;
      pb = bus.data_b;
      pl = bus.last_k;
      if (bus.valid_in) begin
        res_seen++;
        last_res_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end
  task automatic wr(input logic sel, input int addr, input logic [31:0] d);
    wr_en = 1;
    wr_sel = sel;
    wr_addr = 4'(addr);
    wr_data = d;
    tick();
    wr_en = 0;
  endtask
  task automatic begin_run();
    exp_a.delete();
    exp_b.delete();
    exp_l.delete();
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        for (int k = 0; k < K; k++) begin
          exp_a.push_back(am[k*M + m]);
          exp_b.push_back(bm[k*N + n]);
          exp_l.push_back(k == K - 1);
        end
    idx = 0;
    res_seen = 0;
    lastk_cnt = 0;
    acc = 0;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic run(input bit rnd, input bit inj);
    int d0 = done_cnt;
    bit did = 0;
    for (int t = 0; t < 3000 && done_cnt == d0; t++) begin
      if (rnd) bus.ready_in = 1'($urandom_range(0, 1));
      if (inj && !did && idx >= 10) begin
        start = 1;
        wr_en = 1;
        wr_sel = 0;
        wr_addr = 0;
        wr_data = 999;
        did = 1;
      end
      tick();
      start = 0;
      wr_en = 0;
    end
    bus.ready_in = 1;
    check("done_seen", 32'(done_cnt - d0), 1);
    repeat (3) tick();
    check("done_once", 32'(done_cnt - d0), 1);
    check("busy_after", 32'(busy), 0);
    check("valid_after", 32'(bus.valid_out), 0);
    check("xfer_count", 32'(idx), 64);
    check("lastk_count", 32'(lastk_cnt), 16);
    check("result_count", 32'(res_seen), 16);
    check("done_latency", 32'(done_cyc), 32'(last_res_cyc + 1));
  endtask
  task automatic verify_c();
    for (int i = 0; i < M*N; i++) begin
      rd_addr = 4'(i);
      #1;
      check($sformatf("c_buf%0d", i), rd_data, c_exp(i));
    end
  endtask
  task automatic read_c(input int i, input logic [31:0] e);
    rd_addr = 4'(i);
    #1;
    check($sformatf("c_lit%0d", i), rd_data, e);
  endtask
  initial begin
    bus.ready_in = 0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_valid", 32'(bus.valid_out), 0);
    check("rst_last_k", 32'(bus.last_k), 0);
    check("rst_data_a", bus.data_a, 0);
    check("rst_data_b", bus.data_b, 0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 16; i++) begin
      am[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
      bm[i] = 32'(10 * (i / 4) + i % 4);
      wr(0, i, am[i]);
      wr(1, i, bm[i]);
    end
    bus.ready_in = 1;
    begin_run();
    check("first_valid", 32'(bus.valid_out), 1);
    check("first_a", bus.data_a, 1);
    check("first_b", bus.data_b, 0);
    check("first_busy", 32'(busy), 1);
    run(0, 0);
    verify_c();
    read_c(11, 23);
    rq.push_back('{cyc + 1, 32'hDEAD});
    repeat (3) tick();
    check("overrun_set", 32'(overrun), 1);
    read_c(0, 0);
    for (int i = 0; i < 16; i++) begin
      am[i] = 32'(i + 1);
      wr(0, i, am[i]);
    end
    begin_run();
    check("overrun_clr", 32'(overrun), 0);
    run(1, 1);
    verify_c();
    read_c(0, 620);
    read_c(15, 920);
    begin_run();
    for (int t = 0; t < 200 && idx < 19; t++) tick();
    check("reach_xfer20", 32'(idx), 19);
    #2;
    rst_n = 0;
    rq.delete();
    #1;
    check("arst_valid", 32'(bus.valid_out), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_last_k", 32'(bus.last_k), 0);
    repeat (2) tick();
    rst_n = 1;
    tick();
    begin_run();
    check("replay_a", bus.data_a, 1);
    check("replay_b", bus.data_b, 0);
    run(0, 0);
    verify_c();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
